hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage core. Produces the `flushE` input of the ID/EX register, plus the stall, flush and forwarding selects for the other stages. It also sequences the multi-cycle multiply/divide occupancy of EX. It inspects register indices and write enables from the D, E, M and W stages, resolves load-use, redirect and multi-cycle hazards, and tracks multi-cycle operations with a small FSM.

## Interface
- `MD_LATENCY`, 4: total EX occupancy in cycles of a multiply/divide op; legal range 2..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rsD`, `rtD`  in  5 each  source registers of the instruction in ID.
- `rsE`, `rtE`  in  5 each  source registers of the instruction in EX.
- `writeRegE`, `writeRegM`, `writeRegW`  in  5 each  destination register per stage.
- `Regfile_weE`, `Regfile_weM`, `Regfile_weW`  in  1 each  register write enable per stage.
- `memToRegE`  in  1  instruction in EX is a load.
- `redirectD`  in  1  branch taken or jump resolved in ID.
- `mdStartE`  in  1  a multiply/divide op is in EX this cycle.
- `stallF`, `stallD`, `stallE`  out  1 each  hold the PC, IF/ID and ID/EX registers.
- `flushD`, `flushE`  out  1 each  clear the IF/ID and ID/EX registers.
- `forwardAE`, `forwardBE`  out  2 each  EX operand select: 00 regfile, 01 W result, 10 M result.
- `mdBusy`, `mdDone`  out  1 each  multi-cycle op in progress / completes this cycle.

## Operation
- Load-use condition, `lwstall`:
  - `memToRegE & Regfile_weE & (writeRegE != 0) & (writeRegE == rsD | writeRegE == rtD)`.
  - Effect: `stallF = stallD = 1` and `flushE = 1`.
- Redirect: `flushD = redirectD & ~stallD`.
  - A stall wins over a redirect. The branch stays in ID and re-resolves next cycle.
- Forwarding, operand A (B identical using `rtE`):
  - 10 if `Regfile_weM & writeRegM != 0 & writeRegM == rsE`.
  - Otherwise 01 if the same test passes for W.
  - Otherwise 00.
  - M has priority over W. Register 0 never forwards.
- MD FSM states are IDLE, BUSY and DONE.
  - IDLE→BUSY when `mdStartE` is sampled; the 4-bit counter loads `MD_LATENCY-1`.
  - BUSY decrements the counter each cycle. BUSY→DONE on the edge where the counter equals 1.
  - DONE→IDLE unconditionally.
  - `mdStartE` is ignored in BUSY and DONE.
- `mdStall = (IDLE & mdStartE) | BUSY`.
  - While `mdStall`: `stallF = stallD = stallE = 1`, `flushE = 0`, `flushD = 0`.
  - `mdStall` overrides `lwstall`'s flush of EX, so the MD op itself is never squashed.
- `mdBusy = mdStall`. `mdDone = 1` only in DONE.
- While `rst` is low:
  - FSM is forced to IDLE and the counter to 0.
  - All outputs are 0.

## Timing
- Forwarding, `lwstall`, `flushD` and `flushE` are combinational from the same-cycle inputs.
- MD occupancy: with `mdStartE` in cycle T, stalls are asserted in T..T+MD_LATENCY-1.
  - BUSY lasts `MD_LATENCY-1` cycles.
  - `mdDone` pulses in cycle T+MD_LATENCY, with stalls deasserted.
- `mdStartE` and `lwstall` in the same cycle: the MD stall governs and `flushE = 0`. The load-use condition is re-evaluated when the stall releases.
- Reset asserted mid-BUSY: stalls drop immediately (asynchronous). After release the FSM is in IDLE and `mdDone` does not pulse.
- Reset deassertion is synchronized externally; the block expects it clean relative to `clk`.

## Configuration
- `HAZARD_STATS_EN` defined adds two 32-bit outputs, `stallCycles` and `flushCount`.
  - `stallCycles` increments on every cycle with `stallD = 1`.
  - `flushCount` increments on every cycle with `flushD | flushE`.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port nor counter exists, and the remaining behaviour is identical.

## Test plan
- Load-use: `memToRegE=1`, `Regfile_weE=1`, `writeRegE=5`, `rsD=5` → `stallF=stallD=flushE=1`, `flushD=0`. Repeat with `writeRegE=0` → all 0.
- Forward priority: `rsE=rtE=7`, `writeRegM=writeRegW=7`, both enables 1 → `forwardAE=forwardBE=10`. Clear `Regfile_weM` → 01. `rsE=0` → 00.
- Redirect vs stall: `redirectD=1` alone → `flushD=1`. `redirectD=1` together with load-use → `flushD=0`, `stallD=1`.
- MD sequencing, `MD_LATENCY=4`, `mdStartE` pulse at T:
  - `stallE=1` for T..T+3.
  - `mdDone=1` at T+4.
  - A second `mdStartE` at T+2 is ignored.
- Reset mid-BUSY: drop `rst` at T+2 → stalls 0 within the same cycle. After release, `mdBusy=0` and no `mdDone`.
- With `HAZARD_STATS_EN`: 3 load-use cycles plus one MD op of 4 → `stallCycles=7`, `flushCount=3`.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/redirect/forwarding control and multiply-divide EX occupancy FSM.
// Define HAZARD_STATS_EN to add saturating stallCycles/flushCount counters.
module hazard_unit #(
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegE,
    input  logic [4:0] writeRegM,
    input  logic [4:0] writeRegW,
    input  logic       Regfile_weE,
    input  logic       Regfile_weM,
    input  logic       Regfile_weW,
    input  logic       memToRegE,
    input  logic       redirectD,
    input  logic       mdStartE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mdBusy,
    output logic       mdDone
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCount
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
    localparam logic [3:0] LOAD = 4'(MD_LATENCY - 1);
    md_state_t  r_state, w_next;
    logic [3:0] r_cnt, w_cnt;
    logic       w_lw, w_md_stall;

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (Regfile_weM && writeRegM != 5'd0 && writeRegM == src) return 2'b10;
        if (Regfile_weW && writeRegW != 5'd0 && writeRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            IDLE: if (mdStartE) begin
                w_next = BUSY;
                w_cnt  = LOAD;
            end
            BUSY: begin
                w_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_lw = memToRegE && Regfile_weE && writeRegE != 5'd0 &&
                  (writeRegE == rsD || writeRegE == rtD);
    assign w_md_stall = (r_state == IDLE && mdStartE) || r_state == BUSY;

    // Every output is gated by rst so reset silences the combinational paths too.
    assign stallF    = rst && (w_lw || w_md_stall);
    assign stallD    = stallF;
    assign stallE    = rst && w_md_stall;
    assign flushE    = rst && w_lw && !w_md_stall;
    assign flushD    = rst && redirectD && !stallD;
    assign forwardAE = rst ? fwd(rsE) : 2'b00;
    assign forwardBE = rst ? fwd(rtE) : 2'b00;
    assign mdBusy    = stallE;
    assign mdDone    = rst && r_state == DONE;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles, r_flush_count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (stallD && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
            if ((flushD || flushE) && r_flush_count != '1) r_flush_count <= r_flush_count + 32'd1;
        end
    end
    assign stallCycles = r_stall_cycles;
    assign flushCount  = r_flush_count;
`endif
endmodule
